// File: rtl/stream_pkg.sv
// Shared stream-path definitions: serializer state encodings and a width helper
// used by the FIFO and the width converters.
package stream_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    // Counter/pointer width for 'value' states; never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/stream_width_serializer.sv
// Pops IN_WIDTH-bit words from the FIFO and emits them as RATIO narrower beats,
// one beat per cycle with no bubble between consecutive words.
module stream_width_serializer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic [IN_WIDTH-1:0]  in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_grant_o,
    output logic [OUT_WIDTH-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_grant_i,
    output logic                 out_last_o,
    output logic                 busy_o
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = clog2_min1(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    generate
        if (OUT_WIDTH < 1 || IN_WIDTH < OUT_WIDTH || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_params
            $error("ERROR: stream_width_serializer needs OUT_WIDTH>=1 and IN_WIDTH a multiple of OUT_WIDTH");
        end
    endgenerate

    ser_state_e            state_q, state_d;
    logic [IN_WIDTH-1:0]   wreg_q, wreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      chunk_idx;
    logic                  last;

    assign last      = (cnt_q == LAST_CNT);
    // MSB-first order walks the same part-select from the top chunk down.
    assign chunk_idx = (LSB_FIRST != 0) ? cnt_q : (LAST_CNT - cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SER_IDLE;
            wreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wreg_q  <= wreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wreg_d      = wreg_q;
        cnt_d       = cnt_q;
        in_grant_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        busy_o      = 1'b0;

        case (state_q)
            SER_IDLE: begin
                in_grant_o = 1'b1;
                if (in_valid_i) begin
                    wreg_d  = in_data_i;
                    cnt_d   = '0;
                    state_d = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
                out_data_o  = wreg_q[int'(chunk_idx)*OUT_WIDTH +: OUT_WIDTH];
                out_last_o  = last;
                // Popping on the last accepted beat refills the word without a gap.
                in_grant_o  = out_grant_i & last;
                if (out_grant_i) begin
                    if (!last) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                        if (in_valid_i) begin
                            wreg_d = in_data_i;
                        end else begin
                            state_d = SER_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = SER_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Flush wins: nothing is popped, so no FIFO word is lost.
        if (clear_i) begin
            state_d    = SER_IDLE;
            cnt_d      = '0;
            wreg_d     = wreg_q;
            in_grant_o = 1'b0;
        end
    end

endmodule
